writeback_stage: RTL and testbench

- Parametrised successor to the single-mux writeback cycle of the RISC-V pipeline core.
- Owns the MEM/WB pipeline register and performs load-data alignment with sign/zero extension.
- Selects among four result sources and drives the register-file write port.
- Supports stall and flush, and optionally counts retired instructions.
- Sits between memory_cycle and the register file / hazard unit.

---
 rtl/wb_pkg.sv | 19 +
 rtl/writeback_stage_if.sv | 35 +++
 rtl/writeback_stage_load_extend.sv | 34 +++
 rtl/writeback_stage.sv | 79 +++++++
 tb/tb_writeback_stage.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the writeback stage (result source select, load funct3)
package wb_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_IMM  = 2'b11
    } res_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: M-stage inputs, stall/flush controls and W-stage outputs of the writeback stage
interface writeback_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
);
    logic              ValidM;
    logic              RegWriteM;
    logic [1:0]        ResultSrcM;
    logic [2:0]        Funct3M;
    logic [REG_AW-1:0] RdM;
    logic [XLEN-1:0]   ALU_ResultM;
    logic [XLEN-1:0]   ReadDataM;
    logic [XLEN-1:0]   PCPlus4M;
    logic [XLEN-1:0]   ImmExtM;
    logic              StallW;
    logic              FlushW;
    logic              RegWriteW;
    logic [REG_AW-1:0] RdW;
    logic [XLEN-1:0]   ResultW;
    logic              ValidW;
    logic [CNT_W-1:0]  InstRetW;

    modport master (
        output ValidM, RegWriteM, ResultSrcM, Funct3M, RdM, ALU_ResultM,
               ReadDataM, PCPlus4M, ImmExtM, StallW, FlushW,
        input  RegWriteW, RdW, ResultW, ValidW, InstRetW
    );

    modport slave (
        input  ValidM, RegWriteM, ResultSrcM, Funct3M, RdM, ALU_ResultM,
               ReadDataM, PCPlus4M, ImmExtM, StallW, FlushW,
        output RegWriteW, RdW, ResultW, ValidW, InstRetW
    );
endinterface

// File: rtl/writeback_stage_load_extend.sv
// load_extend: picks the addressed byte/half/word out of the raw memory word and sign/zero-extends it
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OW   = $clog2(XLEN / 8)
) (
    input  logic [2:0]      funct3,
    input  logic [OW-1:0]   offset,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;

    // halfword ignores offset[0]; the upper word lane exists only when XLEN is 64
    assign b = 8'(raw >> {offset, 3'b000});
    assign h = 16'(raw >> {offset[OW-1:1], 4'b0000});
    assign w = (XLEN == 64) ? 32'(raw >> {offset[OW-1], 5'b00000}) : 32'(raw);

    always_comb begin
        data = raw;
        case (funct3)
            F3_LB:   data = XLEN'($signed(b));
            F3_LBU:  data = XLEN'(b);
            F3_LH:   data = XLEN'($signed(h));
            F3_LHU:  data = XLEN'(h);
            F3_LW:   data = XLEN'($signed(w));
            F3_LWU:  data = (XLEN == 64) ? XLEN'(w) : raw;
            default: data = raw;
        endcase
    end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register, load extension and result mux driving the register-file write port.
// Define WB_INSTRET_EN to build the retired-instruction counter; otherwise InstRetW is tied to 0.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
) (
    input logic              clk,
    input logic              rst,
    writeback_stage_if.slave bus
);
    localparam int OW = $clog2(XLEN / 8);

    logic              valid_q;
    logic              rw_q;
    res_src_e          rs_q;
    logic [2:0]        f3_q;
    logic [REG_AW-1:0] rd_q;
    logic [XLEN-1:0]   alu_q;
    logic [XLEN-1:0]   rdata_q;
    logic [XLEN-1:0]   pc4_q;
    logic [XLEN-1:0]   imm_q;
    logic [XLEN-1:0]   load_data;

    // a flush still captures the payload but kills valid/regwrite, and wins over a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            rs_q    <= RES_ALU;
            f3_q    <= '0;
            rd_q    <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            pc4_q   <= '0;
            imm_q   <= '0;
        end else if (bus.FlushW || !bus.StallW) begin
            valid_q <= bus.ValidM & ~bus.FlushW;
            rw_q    <= bus.RegWriteM & ~bus.FlushW;
            rs_q    <= res_src_e'(bus.ResultSrcM);
            f3_q    <= bus.Funct3M;
            rd_q    <= bus.RdM;
            alu_q   <= bus.ALU_ResultM;
            rdata_q <= bus.ReadDataM;
            pc4_q   <= bus.PCPlus4M;
            imm_q   <= bus.ImmExtM;
        end
    end

    load_extend #(.XLEN(XLEN), .OW(OW)) u_load_extend (
        .funct3 (f3_q),
        .offset (alu_q[OW-1:0]),
        .raw    (rdata_q),
        .data   (load_data)
    );

    assign bus.ValidW    = valid_q;
    assign bus.RdW       = rd_q;
    assign bus.RegWriteW = rw_q & valid_q & (rd_q != '0);
    assign bus.ResultW   = (rs_q == RES_ALU)  ? alu_q :
                           (rs_q == RES_LOAD) ? load_data :
                           (rs_q == RES_PC4)  ? pc4_q : imm_q;

`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0] cnt_q;

    // retire when the instruction leaves W; a killed slot has valid_q=0 so it never counts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (valid_q && !bus.StallW) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign bus.InstRetW = cnt_q;
`else
    assign bus.InstRetW = CNT_W'(0);
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed checks of reset, load extension, result mux, x0 suppression, stall/flush and counter wrap
module tb_writeback_stage;
    import wb_pkg::*;

`ifdef WB_INSTRET_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    writeback_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(4)) wbi ();

    writeback_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (wbi.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] src, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4, input logic [31:0] imm);
        wbi.ValidM      = v;
        wbi.RegWriteM   = rw;
        wbi.ResultSrcM  = src;
        wbi.Funct3M     = f3;
        wbi.RdM         = rd;
        wbi.ALU_ResultM = alu;
        wbi.ReadDataM   = rdata;
        wbi.PCPlus4M    = pc4;
        wbi.ImmExtM     = imm;
    endtask

    task automatic do_reset;
        drive(0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        wbi.StallW = 1'b0;
        wbi.FlushW = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [3:0] exp_cnt(input int n);
        return CNT_ON ? 4'(n) : 4'd0;
    endfunction

    task automatic test_reset;
        do_reset();
        rst = 1'b1;
        tick();
        total++; if (wbi.ValidW !== 1'b0) $display("FAIL reset_valid: got %b want 0", wbi.ValidW); else passed++;
        total++; if (wbi.RegWriteW !== 1'b0) $display("FAIL reset_regwrite: got %b want 0", wbi.RegWriteW); else passed++;
        total++; if (wbi.RdW !== 5'd0) $display("FAIL reset_rd: got %0d want 0", wbi.RdW); else passed++;
        total++; if (wbi.ResultW !== 32'h0) $display("FAIL reset_result: got %h want 0", wbi.ResultW); else passed++;
        total++; if (wbi.InstRetW !== 4'd0) $display("FAIL reset_instret: got %0d want 0", wbi.InstRetW); else passed++;
        rst = 1'b0;
        drive(1, 1, RES_ALU, F3_LB, 5'd3, 32'h7, 32'h0, 32'h0, 32'h0);
        repeat (6) tick();
        total++; if (wbi.ValidW !== 1'b1) $display("FAIL pre_reset_valid: got %b want 1", wbi.ValidW); else passed++;
        total++; if (wbi.InstRetW !== exp_cnt(5)) $display("FAIL pre_reset_instret: got %0d want %0d", wbi.InstRetW, exp_cnt(5)); else passed++;
        rst = 1'b1;
        #1;
        total++; if (wbi.ValidW !== 1'b0) $display("FAIL async_reset_valid: got %b want 0", wbi.ValidW); else passed++;
        total++; if (wbi.RegWriteW !== 1'b0) $display("FAIL async_reset_regwrite: got %b want 0", wbi.RegWriteW); else passed++;
        total++; if (wbi.RdW !== 5'd0) $display("FAIL async_reset_rd: got %0d want 0", wbi.RdW); else passed++;
        total++; if (wbi.ResultW !== 32'h0) $display("FAIL async_reset_result: got %h want 0", wbi.ResultW); else passed++;
        total++; if (wbi.InstRetW !== 4'd0) $display("FAIL async_reset_instret: got %0d want 0", wbi.InstRetW); else passed++;
        tick();
        rst = 1'b0;
        drive(0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_load;
        logic [2:0]  f3s  [7] = '{F3_LB, F3_LBU, F3_LHU, F3_LH, F3_LH, F3_LW, F3_LD};
        logic [31:0] offs [7] = '{32'h3, 32'h3, 32'h2, 32'h2, 32'h1, 32'h2, 32'h1};
        logic [31:0] exps [7] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF,
                                  32'h00007F01, 32'h80FF7F01, 32'h80FF7F01};
        for (int i = 0; i < 7; i++) begin
            drive(1, 1, RES_LOAD, f3s[i], 5'd1, offs[i], 32'h80FF7F01, 32'h0, 32'h0);
            tick();
            total++;
            if (wbi.ResultW !== exps[i])
                $display("FAIL load_%0d f3=%b off=%0d: got %h want %h", i, f3s[i], offs[i], wbi.ResultW, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_sources;
        drive(1, 1, RES_ALU, F3_LB, 5'd2, 32'hDEADBEEF, 32'h11111111, 32'h104, 32'h12345000);
        tick();
        total++; if (wbi.ResultW !== 32'hDEADBEEF) $display("FAIL src_alu: got %h want deadbeef", wbi.ResultW); else passed++;
        drive(1, 1, RES_PC4, F3_LB, 5'd2, 32'hDEADBEEF, 32'h11111111, 32'h104, 32'h12345000);
        tick();
        total++; if (wbi.ResultW !== 32'h104) $display("FAIL src_pc4: got %h want 00000104", wbi.ResultW); else passed++;
        drive(1, 1, RES_IMM, F3_LB, 5'd2, 32'hDEADBEEF, 32'h11111111, 32'h104, 32'h12345000);
        tick();
        total++; if (wbi.ResultW !== 32'h12345000) $display("FAIL src_imm: got %h want 12345000", wbi.ResultW); else passed++;
    endtask

    task automatic test_x0;
        drive(1, 1, RES_ALU, F3_LB, 5'd0, 32'h1, 32'h0, 32'h0, 32'h0);
        tick();
        total++; if (wbi.RegWriteW !== 1'b0) $display("FAIL x0_suppress: got %b want 0", wbi.RegWriteW); else passed++;
        drive(1, 1, RES_ALU, F3_LB, 5'd5, 32'h1, 32'h0, 32'h0, 32'h0);
        tick();
        total++; if (wbi.RegWriteW !== 1'b1) $display("FAIL x5_write: got %b want 1", wbi.RegWriteW); else passed++;
        total++; if (wbi.RdW !== 5'd5) $display("FAIL x5_rd: got %0d want 5", wbi.RdW); else passed++;
        drive(0, 1, RES_ALU, F3_LB, 5'd5, 32'h1, 32'h0, 32'h0, 32'h0);
        tick();
        total++; if (wbi.RegWriteW !== 1'b0) $display("FAIL invalid_write: got %b want 0", wbi.RegWriteW); else passed++;
    endtask

    task automatic test_stall_flush;
        do_reset();
        drive(1, 1, RES_ALU, F3_LB, 5'd7, 32'h55, 32'h0, 32'h0, 32'h0);
        tick();
        total++; if (wbi.ResultW !== 32'h55) $display("FAIL stall_load_a: got %h want 00000055", wbi.ResultW); else passed++;
        drive(1, 1, RES_ALU, F3_LB, 5'd9, 32'hAA, 32'h0, 32'h0, 32'h0);
        wbi.StallW = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (wbi.ResultW !== 32'h55) $display("FAIL stall_%0d_result: got %h want 00000055", i, wbi.ResultW); else passed++;
            total++; if (wbi.RdW !== 5'd7) $display("FAIL stall_%0d_rd: got %0d want 7", i, wbi.RdW); else passed++;
            total++; if (wbi.ValidW !== 1'b1) $display("FAIL stall_%0d_valid: got %b want 1", i, wbi.ValidW); else passed++;
            total++; if (wbi.InstRetW !== 4'd0) $display("FAIL stall_%0d_instret: got %0d want 0", i, wbi.InstRetW); else passed++;
        end
        wbi.FlushW = 1'b1;
        tick();
        total++; if (wbi.ValidW !== 1'b0) $display("FAIL flush_valid: got %b want 0", wbi.ValidW); else passed++;
        total++; if (wbi.RegWriteW !== 1'b0) $display("FAIL flush_regwrite: got %b want 0", wbi.RegWriteW); else passed++;
        total++; if (wbi.InstRetW !== 4'd0) $display("FAIL flush_instret: got %0d want 0", wbi.InstRetW); else passed++;
        wbi.FlushW = 1'b0;
        wbi.StallW = 1'b0;
        tick();
        total++; if (wbi.ResultW !== 32'hAA) $display("FAIL after_flush_result: got %h want 000000aa", wbi.ResultW); else passed++;
        total++; if (wbi.InstRetW !== 4'd0) $display("FAIL after_flush_instret: got %0d want 0", wbi.InstRetW); else passed++;
        drive(0, 0, RES_ALU, F3_LB, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        total++; if (wbi.InstRetW !== exp_cnt(1)) $display("FAIL retire_after_flush: got %0d want %0d", wbi.InstRetW, exp_cnt(1)); else passed++;
    endtask

    task automatic test_back_to_back;
        do_reset();
        drive(1, 1, RES_ALU, F3_LB, 5'd4, 32'h9, 32'h0, 32'h0, 32'h0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            total++;
            if (wbi.InstRetW !== exp_cnt((k - 1) % 16))
                $display("FAIL wrap_edge_%0d: got %0d want %0d", k, wbi.InstRetW, exp_cnt((k - 1) % 16));
            else passed++;
        end
        drive(0, 0, RES_ALU, F3_LB, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_load();
        test_sources();
        test_x0();
        test_stall_flush();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
